fwd_hazard_unit: RTL and testbench

- Parametrised successor to the pipeline forwarding controller.
- Sits beside ID/EX. Compares ID-stage source registers against a configurable number of downstream destination stages and issues registered per-source forwarding selects for EX.
- Adds behaviour the earlier controller lacks: x0 exclusion, write-enable qualification, multi-cycle load-use stall FSM, branch flush sequencing.

---
 rtl/fwd_hazard_unit.sv | 129 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects plus load-use stall / branch flush sequencing beside ID/EX.
// Define HAZARD_PERF_EN to build the stall and flush performance counters.
module fwd_hazard_unit #(
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned FWD_STAGES     = 3,
  parameter int unsigned REG_AW         = 5,
  parameter int unsigned LOAD_AVAIL_STG = 1,
  parameter int unsigned SEL_W          = $clog2(FWD_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]    id_rs_addr,
  input  logic [NUM_SRC-1:0]           id_rs_used,
  input  logic [FWD_STAGES*REG_AW-1:0] stg_rd_addr,
  input  logic [FWD_STAGES-1:0]        stg_wb_en,
  input  logic [FWD_STAGES-1:0]        stg_is_load,
  input  logic                         br_taken,
  output logic [NUM_SRC*SEL_W-1:0]     fwd_sel,
  output logic                         stall_if,
  output logic                         stall_id,
  output logic                         flush_id,
  output logic                         flush_ex,
  output logic [31:0]                  perf_stall_cnt,
  output logic [31:0]                  perf_flush_cnt
);

  localparam int unsigned CNT_W = $clog2(FWD_STAGES) + 1;

  typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel_q, fwd_sel_d, win_sel;
  logic [CNT_W-1:0]           need_len;
  logic [REG_AW-1:0]          rs_cur;
  logic                       found;
  logic                       stall, flush;

  // Per source: youngest qualifying producer wins; loads too young to forward set the stall length.
  always_comb begin
    win_sel  = '0;
    need_len = '0;
    rs_cur   = '0;
    found    = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      rs_cur = id_rs_addr[i*REG_AW +: REG_AW];
      found  = 1'b0;
      for (int k = 0; k < int'(FWD_STAGES); k++) begin
        if (!found && id_valid && id_rs_used[i] && (rs_cur != '0) && stg_wb_en[k] &&
            (stg_rd_addr[k*REG_AW +: REG_AW] == rs_cur)) begin
          found = 1'b1;
          win_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          if (stg_is_load[k] && (k < int'(LOAD_AVAIL_STG)) &&
              (CNT_W'(int'(LOAD_AVAIL_STG) - k) > need_len)) begin
            need_len = CNT_W'(int'(LOAD_AVAIL_STG) - k);
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush   = 1'b0;
    if (br_taken) begin
      flush   = 1'b1;
      cnt_d   = '0;
      state_d = StFlush;
    end else if (state_q == StFlush) begin
      state_d = StRun;
    end else if ((state_q == StStall) && (cnt_q != '0)) begin
      stall   = 1'b1;
      cnt_d   = cnt_q - 1'b1;
      state_d = (cnt_q == CNT_W'(1)) ? StRun : StStall;
    end else if (need_len != '0) begin
      stall   = 1'b1;
      cnt_d   = need_len - 1'b1;
      state_d = (need_len > CNT_W'(1)) ? StStall : StRun;
    end else begin
      state_d = StRun;
    end
  end

  // Bubble into EX whenever ID is held, squashed, or known to be wrong-path.
  assign fwd_sel_d = (stall || flush || (state_q == StFlush)) ? '0 : win_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      fwd_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fwd_sel_q <= fwd_sel_d;
    end
  end

  // Gate with reset so no control pulse leaks out while reset is held.
  assign stall_if = stall & rst;
  assign stall_id = stall & rst;
  assign flush_id = flush & rst;
  assign flush_ex = flush & rst;
  assign fwd_sel  = fwd_sel_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_q <= perf_stall_q + 32'd1;
      if (br_taken && (perf_flush_q != 32'hFFFF_FFFF)) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances (load data usable from MEM / from WB) driven in lockstep
// and compared against a cycle model built from the forwarding and stall rules.
module tb_fwd_hazard_unit;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [4:0]      rs [2];
  logic [1:0]      rs_used;
  logic [4:0]      rd [3];
  logic [2:0]      wb_en;
  logic [2:0]      is_load;
  logic            br;
  logic [9:0]      id_rs_addr;
  logic [14:0]     stg_rd_addr;

  logic [3:0]  fwd_sel_a, fwd_sel_b;
  logic        stall_if_a, stall_id_a, flush_id_a, flush_ex_a;
  logic        stall_if_b, stall_id_b, flush_id_b, flush_ex_b;
  logic [31:0] pstall_a, pflush_a, pstall_b, pflush_b;

  int          checks = 0;
  int          errors = 0;

  // Model state, index 0 = LOAD_AVAIL_STG 1, index 1 = LOAD_AVAIL_STG 2.
  int          las [2];
  int          m_left [2];
  bit          m_flush [2];
  logic [3:0]  m_sel [2];
  logic [31:0] m_pstall [2];
  logic [31:0] m_pflush [2];

  logic [7:0]   obs_ctl, exp_ctl;
  logic [7:0]   obs_sel, exp_sel;
  logic [127:0] obs_perf, exp_perf;

  assign id_rs_addr  = {rs[1], rs[0]};
  assign stg_rd_addr = {rd[2], rd[1], rd[0]};

  always #5 clk = ~clk;

  fwd_hazard_unit #(.LOAD_AVAIL_STG(1)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rs_used(rs_used),
    .stg_rd_addr(stg_rd_addr), .stg_wb_en(wb_en), .stg_is_load(is_load), .br_taken(br),
    .fwd_sel(fwd_sel_a), .stall_if(stall_if_a), .stall_id(stall_id_a), .flush_id(flush_id_a),
    .flush_ex(flush_ex_a), .perf_stall_cnt(pstall_a), .perf_flush_cnt(pflush_a)
  );

  fwd_hazard_unit #(.LOAD_AVAIL_STG(2)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rs_used(rs_used),
    .stg_rd_addr(stg_rd_addr), .stg_wb_en(wb_en), .stg_is_load(is_load), .br_taken(br),
    .fwd_sel(fwd_sel_b), .stall_if(stall_if_b), .stall_id(stall_id_b), .flush_id(flush_id_b),
    .flush_ex(flush_ex_b), .perf_stall_cnt(pstall_b), .perf_flush_cnt(pflush_b)
  );

  function automatic void model_eval(input int d, output logic [3:0] ctl,
                                     output logic [3:0] nsel, output int left_n,
                                     output bit flush_n);
    int win [2];
    int len;
    bit st, fl;
    len = 0;
    for (int i = 0; i < 2; i++) begin
      win[i] = -1;
      if (id_valid && rs_used[i] && rs[i] != 5'd0) begin
        for (int k = 2; k >= 0; k--) if (wb_en[k] && rd[k] == rs[i]) win[i] = k;
      end
      if (win[i] >= 0 && is_load[win[i]] && win[i] < las[d] && las[d] - win[i] > len)
        len = las[d] - win[i];
    end
    st = 1'b0;
    fl = 1'b0;
    left_n = m_left[d];
    flush_n = 1'b0;
    if (br) begin
      fl = 1'b1;
      flush_n = 1'b1;
      left_n = 0;
    end else if (m_flush[d]) begin
      left_n = 0;
    end else if (m_left[d] > 0) begin
      st = 1'b1;
      left_n = m_left[d] - 1;
    end else if (len > 0) begin
      st = 1'b1;
      left_n = len - 1;
    end
    ctl = {st, st, fl, fl};
    nsel = 4'd0;
    if (!st && !fl && !m_flush[d]) begin
      for (int i = 0; i < 2; i++) if (win[i] >= 0) nsel[i*2 +: 2] = 2'(win[i] + 1);
    end
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_left[d] = 0;
      m_flush[d] = 1'b0;
      m_sel[d] = 4'd0;
      m_pstall[d] = 32'd0;
      m_pflush[d] = 32'd0;
    end
  endtask

  task automatic clear_inputs();
    id_valid = 1'b0;
    rs_used = 2'b00;
    br = 1'b0;
    wb_en = 3'b000;
    is_load = 3'b000;
    for (int i = 0; i < 2; i++) rs[i] = 5'd0;
    for (int k = 0; k < 3; k++) rd[k] = 5'd0;
  endtask

  // Advance one cycle: sample control outputs mid-cycle, then registered state after the edge.
  task automatic tick();
    logic [3:0] c [2];
    logic [3:0] ns [2];
    int l [2];
    bit f [2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) model_eval(d, c[d], ns[d], l[d], f[d]);
    exp_ctl = {c[1], c[0]};
    obs_ctl = {stall_if_b, stall_id_b, flush_id_b, flush_ex_b,
               stall_if_a, stall_id_a, flush_id_a, flush_ex_a};
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      m_left[d] = l[d];
      m_flush[d] = f[d];
      m_sel[d] = ns[d];
      if (c[d][3] && m_pstall[d] != 32'hFFFF_FFFF) m_pstall[d] = m_pstall[d] + 32'd1;
      if (br && m_pflush[d] != 32'hFFFF_FFFF) m_pflush[d] = m_pflush[d] + 32'd1;
    end
    #1;
    exp_sel = {m_sel[1], m_sel[0]};
    obs_sel = {fwd_sel_b, fwd_sel_a};
    obs_perf = {pstall_b, pflush_b, pstall_a, pflush_a};
`ifdef HAZARD_PERF_EN
    exp_perf = {m_pstall[1], m_pflush[1], m_pstall[0], m_pflush[0]};
`else
    exp_perf = '0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    id_valid = 1'b1;
    rs_used = 2'b11;
    rs[0] = 5'd4;
    rd[0] = 5'd4;
    wb_en = 3'b001;
    is_load = 3'b001;
    br = 1'b1;
    model_reset();
    #2;
    obs_ctl = {stall_if_b, stall_id_b, flush_id_b, flush_ex_b,
               stall_if_a, stall_id_a, flush_id_a, flush_ex_a};
    checks++;
    if (obs_ctl !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctl: got %b expected %b", obs_ctl, 8'd0);
    end
    @(posedge clk);
    #1;
    obs_sel = {fwd_sel_b, fwd_sel_a};
    obs_perf = {pstall_b, pflush_b, pstall_a, pflush_a};
    checks++;
    if (obs_sel !== 8'd0) begin
      errors++;
      $display("FAIL reset_sel: got %h expected %h", obs_sel, 8'd0);
    end
    checks++;
    if (obs_perf !== 128'd0) begin
      errors++;
      $display("FAIL reset_perf: got %h expected 0", obs_perf);
    end
    clear_inputs();
    rst = 1'b1;
  endtask

  task automatic test_forward_priority();
    clear_inputs();
    id_valid = 1'b1;
    rs_used = 2'b01;
    rs[0] = 5'd5;
    for (int k = 0; k < 3; k++) rd[k] = 5'd5;
    wb_en = 3'b111;
    tick();
    checks++;
    if (obs_ctl !== exp_ctl) begin
      errors++;
      $display("FAIL fwd_prio_ctl: got %b expected %b", obs_ctl, exp_ctl);
    end
    checks++;
    if (obs_sel !== exp_sel || fwd_sel_a[1:0] !== 2'd1) begin
      errors++;
      $display("FAIL fwd_prio_sel: got %h expected %h (src0 must be 1)", obs_sel, exp_sel);
    end
  endtask

  task automatic test_x0_qualify();
    clear_inputs();
    id_valid = 1'b1;
    rs_used = 2'b11;
    rs[0] = 5'd0;
    rs[1] = 5'd7;
    rd[0] = 5'd0;
    rd[1] = 5'd7;
    wb_en = 3'b001;
    tick();
    checks++;
    if (obs_ctl !== exp_ctl || obs_ctl !== 8'd0) begin
      errors++;
      $display("FAIL x0_qual_ctl: got %b expected %b", obs_ctl, exp_ctl);
    end
    checks++;
    if (obs_sel !== exp_sel || obs_sel !== 8'd0) begin
      errors++;
      $display("FAIL x0_qual_sel: got %h expected %h", obs_sel, exp_sel);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    id_valid = 1'b1;
    rs_used = 2'b10;
    rs[1] = 5'd3;
    for (int c = 0; c < 4; c++) begin
      wb_en = 3'b000;
      is_load = 3'b000;
      if (c < 3) begin
        rd[c] = 5'd3;
        wb_en[c] = 1'b1;
        is_load[c] = 1'b1;
      end
      tick();
      checks++;
      if (obs_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL load_use_ctl c%0d: got %b expected %b", c, obs_ctl, exp_ctl);
      end
      checks++;
      if (obs_sel !== exp_sel) begin
        errors++;
        $display("FAIL load_use_sel c%0d: got %h expected %h", c, obs_sel, exp_sel);
      end
      if (c == 1) begin
        checks++;
        if (fwd_sel_a[3:2] !== 2'd2 || stall_id_a !== 1'b0) begin
          errors++;
          $display("FAIL load_use_mem_fwd: got sel %0d stall %b expected sel 2 stall 0",
                   fwd_sel_a[3:2], stall_id_a);
        end
      end
    end
  endtask

  task automatic test_load_use_wb_avail();
    int nstall;
    clear_inputs();
    id_valid = 1'b1;
    rs_used = 2'b01;
    rs[0] = 5'd9;
    nstall = 0;
    for (int c = 0; c < 3; c++) begin
      wb_en = 3'b000;
      is_load = 3'b000;
      rd[c] = 5'd9;
      wb_en[c] = 1'b1;
      is_load[c] = 1'b1;
      tick();
      if (obs_ctl[6]) nstall++;
      checks++;
      if (obs_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL las2_ctl c%0d: got %b expected %b", c, obs_ctl, exp_ctl);
      end
    end
    checks++;
    if (nstall != 2 || fwd_sel_b[1:0] !== 2'd3) begin
      errors++;
      $display("FAIL las2_result: got stalls %0d sel %0d expected stalls 2 sel 3",
               nstall, fwd_sel_b[1:0]);
    end
  endtask

  task automatic test_branch_in_stall();
    clear_inputs();
    id_valid = 1'b1;
    rs_used = 2'b01;
    rs[0] = 5'd9;
    rd[0] = 5'd9;
    wb_en = 3'b001;
    is_load = 3'b001;
    tick();
    rd[0] = 5'd0;
    rd[1] = 5'd9;
    wb_en = 3'b010;
    is_load = 3'b010;
    br = 1'b1;
    tick();
    checks++;
    if (obs_ctl !== exp_ctl || obs_ctl[7:4] !== 4'b0011) begin
      errors++;
      $display("FAIL br_stall_flush: got %b expected %b", obs_ctl, exp_ctl);
    end
    br = 1'b0;
    tick();
    checks++;
    if (obs_ctl !== exp_ctl || obs_ctl[7:4] !== 4'b0000 || fwd_sel_b !== 4'd0) begin
      errors++;
      $display("FAIL br_flush_state: got ctl %b sel %h expected ctl %b sel 0",
               obs_ctl, fwd_sel_b, exp_ctl);
    end
    tick();
    checks++;
    if (obs_ctl !== exp_ctl || obs_sel !== exp_sel) begin
      errors++;
      $display("FAIL br_back_to_run: got %b/%h expected %b/%h", obs_ctl, obs_sel, exp_ctl,
               exp_sel);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      id_valid = ($urandom_range(0, 7) != 0);
      rs_used = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) rs[i] = 5'($urandom_range(0, 3));
      for (int k = 0; k < 3; k++) rd[k] = 5'($urandom_range(0, 3));
      wb_en = 3'($urandom_range(0, 7));
      is_load = 3'($urandom_range(0, 7));
      br = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if (obs_ctl !== exp_ctl || obs_sel !== exp_sel) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL random c%0d: got ctl %b sel %h expected ctl %b sel %h",
                   c, obs_ctl, obs_sel, exp_ctl, exp_sel);
      end
    end
    checks++;
    if (obs_perf !== exp_perf) begin
      errors++;
      $display("FAIL random_perf: got %h expected %h", obs_perf, exp_perf);
    end
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    id_valid = 1'b1;
    rs_used = 2'b01;
    rs[0] = 5'd9;
    rd[0] = 5'd9;
    wb_en = 3'b001;
    is_load = 3'b001;
    tick();
    rd[0] = 5'd0;
    rd[1] = 5'd9;
    wb_en = 3'b010;
    is_load = 3'b010;
    #2;
    rst = 1'b0;
    #1;
    obs_ctl = {stall_if_b, stall_id_b, flush_id_b, flush_ex_b,
               stall_if_a, stall_id_a, flush_id_a, flush_ex_a};
    obs_sel = {fwd_sel_b, fwd_sel_a};
    obs_perf = {pstall_b, pflush_b, pstall_a, pflush_a};
    checks++;
    if (obs_ctl !== 8'd0 || obs_sel !== 8'd0) begin
      errors++;
      $display("FAIL mid_stall_reset: got ctl %b sel %h expected 0/0", obs_ctl, obs_sel);
    end
    checks++;
    if (obs_perf !== 128'd0) begin
      errors++;
      $display("FAIL mid_stall_reset_perf: got %h expected 0", obs_perf);
    end
    model_reset();
    @(posedge clk);
    #1;
    clear_inputs();
    rst = 1'b1;
    tick();
    checks++;
    if (obs_ctl !== exp_ctl || obs_sel !== exp_sel) begin
      errors++;
      $display("FAIL after_reset_run: got %b/%h expected %b/%h", obs_ctl, obs_sel, exp_ctl,
               exp_sel);
    end
  endtask

  initial begin
    las[0] = 1;
    las[1] = 2;
    test_reset();
    test_forward_priority();
    test_x0_qualify();
    test_load_use();
    test_load_use_wb_avail();
    test_branch_in_stall();
    test_random();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
